// File: rtl/npu_host_seq.sv
// Host command sequencer: turns WRITE/READ/POLL commands into single-cycle NPU slave bus accesses.
// Optional macro NPU_HOST_POLL_TIMEOUT_EN bounds POLL to TIMEOUT mismatching reads.
module npu_host_seq #(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_PL,
    S_PL_WAIT,
    S_PL_GAP,
    S_RSP
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

`ifdef NPU_HOST_POLL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Count value held when the mismatching read that reaches the limit is seen.
  localparam logic [15:0] POLL_LAST = 16'(TIMEOUT - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mask_q;
  logic [15:0]         poll_cnt_q;
  logic [15:0]         poll_cnt_d;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                ena_q;
  logic                wea_q;
  logic [ADDR_W-1:0]   addra_q;
  logic [DATA_W-1:0]   dina_q;
  logic                poll_match;
  logic                timeout_hit;

  assign poll_match  = ((douta ^ data_q) & mask_q) == '0;
  assign poll_cnt_d  = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
  assign timeout_hit = TIMEOUT_EN && (poll_cnt_q == POLL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      poll_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
    end else begin
      // Bus outputs idle at zero unless a state below launches an access.
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            data_q     <= cmd_data;
            mask_q     <= cmd_mask;
            poll_cnt_q <= '0;
            case (cmd_op)
              OP_WRITE: begin
                state_q <= S_WR;
                ena_q   <= 1'b1;
                wea_q   <= 1'b1;
                addra_q <= cmd_addr;
                dina_q  <= cmd_data;
              end
              OP_READ: begin
                state_q <= S_RD;
                ena_q   <= 1'b1;
                addra_q <= cmd_addr;
              end
              OP_POLL: begin
                state_q <= S_PL;
                ena_q   <= 1'b1;
                addra_q <= cmd_addr;
              end
              default: begin
                state_q     <= S_RSP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        S_WR: state_q <= S_IDLE;
        S_RD: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          state_q     <= S_RSP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= douta;
          rsp_err_q   <= 1'b0;
        end
        S_PL: state_q <= S_PL_WAIT;
        S_PL_WAIT: begin
          if (poll_match) begin
            state_q     <= S_RSP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= douta;
            rsp_err_q   <= 1'b0;
          end else begin
            poll_cnt_q <= poll_cnt_d;
            if (timeout_hit) begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= douta;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= S_PL_GAP;
            end
          end
        end
        S_PL_GAP: begin
          // Re-issue the poll read from the latched address after one idle cycle.
          state_q <= S_PL;
          ena_q   <= 1'b1;
          addra_q <= addr_q;
        end
        S_RSP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ena       = ena_q;
  assign wea       = wea_q;
  assign addra     = addra_q;
  assign dina      = dina_q;

endmodule

// File: doc/npu_host_seq.md
NPU_HOST_SEQ -- requirements
Module: npu_host_seq

Interface
REQ-001 Parameter ADDR_W, 16, bus address width.
REQ-002 Parameter DATA_W, 32, bus and command data width.
REQ-003 Parameter TIMEOUT, 1024, poll read limit; legal range 1..65535.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_op  in  2  00 WRITE, 01 READ, 10 POLL, 11 illegal.
REQ-009 cmd_addr  in  ADDR_W  target bus address.
REQ-010 cmd_data  in  DATA_W  write data (WRITE) or expected value (POLL).
REQ-011 cmd_mask  in  DATA_W  compare mask (POLL only).
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-014 rsp_data  out  DATA_W  read or poll data.
REQ-015 rsp_err  out  1  illegal opcode or poll timeout.
REQ-016 ena, wea  out  1 each  bus enable and write enable to the NPU slave port.
REQ-017 addra  out  ADDR_W; dina  out  DATA_W  bus address and write data.
REQ-018 douta  in  DATA_W  slave read data, registered by the slave; valid one cycle after the read cycle.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, WR, RD, RD_WAIT, PL, PL_WAIT, PL_GAP, RSP.
REQ-021 cmd_ready is asserted only in IDLE and is decoded combinationally from state.
REQ-022 On accept, the block latches op, addr, data, and mask; commands offered outside IDLE remain pending.
REQ-023 ena, wea, addra, and dina are registered; ena is high for exactly one cycle per bus access; outside access cycles ena=0, wea=0, addra=0, dina=0.
REQ-024 WRITE: the cycle after accept is state WR with ena=1, wea=1, addr, and data; the FSM then returns to IDLE; no response; throughput 1 write per 2 cycles.
REQ-025 READ: the cycle after accept is state RD with ena=1, wea=0; RD_WAIT samples douta at the end of that cycle into rsp_data with rsp_err=0; next state RSP.
REQ-026 POLL: PL issues a read; PL_WAIT compares (douta & mask) against (data & mask).
REQ-027 POLL match: rsp_data=douta, rsp_err=0, next state RSP.
REQ-028 POLL mismatch: poll_cnt increments; the FSM passes through one PL_GAP idle cycle, then returns to PL.
REQ-029 Illegal op: no bus activity; rsp_data=0, rsp_err=1, next state RSP on the cycle after accept.
REQ-030 RSP: rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready=1; on handshake the FSM returns to IDLE and rsp_valid drops the next cycle.
REQ-031 poll_cnt is 16 bits, cleared on every accept, and saturates at 0xFFFF.
REQ-032 A poll whose first read matches produces rsp_valid 3 cycles after accept.

Reset
REQ-033 rst forces IDLE immediately; the in-flight command and any response are discarded.
REQ-034 Reset values: cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_err=0, ena=0, wea=0, addra=0, dina=0, busy=0, poll_cnt=0.
REQ-035 The first command after reset release is accepted on the first edge where cmd_valid=1.

Configuration
REQ-036 Macro NPU_HOST_POLL_TIMEOUT_EN is defined: a POLL that reaches TIMEOUT mismatching reads ends in RSP with rsp_err=1 and rsp_data equal to the last douta.
REQ-037 Macro NPU_HOST_POLL_TIMEOUT_EN is undefined: POLL retries indefinitely and rsp_err is asserted only for illegal op; the TIMEOUT parameter is ignored.

Verification
REQ-038 WRITE addr 0x1000, data 0x04030201 -> exactly one cycle with ena=1, wea=1, addra=0x1000, dina=0x04030201; no rsp_valid.
REQ-039 READ 0x7004, slave returns 0xFFFFFF85 -> rsp_data=0xFFFFFF85, rsp_err=0; exactly one bus read.
REQ-040 POLL 0x7000, mask 0x1, expect 0x1; douta bit0 first set on the 5th read -> 5 reads, each separated by ≥2 idle cycles; rsp_data bit0=1, rsp_err=0.
REQ-041 NPU_HOST_POLL_TIMEOUT_EN defined, TIMEOUT=8, douta constant 0 -> exactly 8 reads, then rsp_err=1, rsp_data=0.
REQ-042 cmd_op=11 followed by rsp_ready held low for 10 cycles -> no ena pulse; rsp_valid, rsp_err=1, and rsp_data stable for all 10 cycles; cmd_ready=0 throughout.
REQ-043 rst asserted during PL_WAIT of a POLL -> all outputs at reset values the same cycle; no response after release; next WRITE executes normally.
